// File: rtl/router_pkg.sv
// Shared router types: flit width, input count, direction and select types.
// Helper picks the lowest set bit of a request vector.
package router_pkg;

  localparam int WL     = 16;
  localparam int NUM_IN = 4;

  typedef enum logic [2:0] {N, E, S, W, L} dir_t;

  typedef logic [WL-1:0] flit_t;
  typedef logic [1:0]    sel_t;

  function automatic sel_t lowest(
    input logic [NUM_IN-1:0] v
  );
    lowest = '0;
    for (int i = NUM_IN-1; i >= 0; i--) begin
      if (v[i]) lowest = sel_t'(i);
    end
  endfunction

endpackage

// File: rtl/starve_ctr.sv
// Saturating lost-arbitration counter for one candidate input.
// Holds under backpressure; clears on a win or a dropped request.
module starve_ctr #(
  parameter int unsigned LIM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic lost,
  input  logic won,
  output logic sat
);

  localparam logic [7:0] LIM8 = 8'(LIM);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || won) begin
      cnt_d = '0;
    end else if (lost && cnt_q != LIM8) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (LIM8 != 8'd0) && req && (cnt_q == LIM8);

endmodule

// File: rtl/out_port_ctrl.sv
// Output-direction drain engine: grant select, FIFO pop and
// registered output flit with starvation override.
module out_port_ctrl
  import router_pkg::*;
#(
  parameter int          WL         = 16,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN-1:0]    req,
  input  logic [1:0]           sel,
  input  logic [NUM_IN*WL-1:0] in_data,
  output logic [NUM_IN-1:0]    pop,
  output logic                 out_valid,
  output logic [WL-1:0]        out_data,
  input  logic                 out_ready,
  output logic                 starve_evt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t        state_q, state_d;
  logic [WL-1:0] data_q, data_d;
  logic          evt_q, evt_d;

  logic [NUM_IN-1:0] sat_vec;
  logic [NUM_IN-1:0] lost_vec;
  logic              load_ok;
  logic              gnt_v;
  logic              ovr;
  sel_t              g;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ctr
    assign lost_vec[i] = req[i] & load_ok & ~pop[i];

    starve_ctr #(
      .LIM (STARVE_LIM)
    ) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .req  (req[i]),
      .lost (lost_vec[i]),
      .won  (pop[i]),
      .sat  (sat_vec[i])
    );
  end

  // Override first, then arbiter index, then any requester (sel/req skew).
  always_comb begin
    gnt_v = 1'b0;
    ovr   = 1'b0;
    g     = '0;
    if (|sat_vec) begin
      gnt_v = 1'b1;
      ovr   = 1'b1;
      g     = lowest(sat_vec);
    end else if (req[sel]) begin
      gnt_v = 1'b1;
      g     = sel;
    end else if (|req) begin
      gnt_v = 1'b1;
      g     = lowest(req);
    end
  end

  always_comb begin
    load_ok = (state_q == EMPTY) | out_ready;
    pop     = '0;
    state_d = state_q;
    data_d  = data_q;
    evt_d   = evt_q;
    if (load_ok) begin
      if (gnt_v) begin
        pop[g]  = ~rst;
        state_d = FULL;
        data_d  = in_data[g*WL +: WL];
        evt_d   = ovr;
      end else begin
        state_d = EMPTY;
        evt_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      evt_q   <= evt_d;
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_data   = data_q;
  assign starve_evt = evt_q;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Directed vector bench for out_port_ctrl: table of single-cycle
// vectors plus hand sequences for starvation, streaming and reset.
module tb_out_port_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [1:0]  sel;
  logic [63:0] in_data;
  logic [3:0]  pop;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        starve_evt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  out_port_ctrl #(
    .WL         (16),
    .STARVE_LIM (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .sel        (sel),
    .in_data    (in_data),
    .pop        (pop),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .starve_evt (starve_evt)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [1:0]  sel;
    logic [15:0] d0, d1, d2, d3;
    logic        rdy;
    logic [3:0]  pop;
    logic        v;
    logic [15:0] dat;
    logic        se;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string nm);
    rst       = t.rst;
    req       = t.req;
    sel       = t.sel;
    in_data   = {t.d3, t.d2, t.d1, t.d0};
    out_ready = t.rdy;
    #1;
    chk({nm, ".pop"}, 32'(pop), 32'(t.pop));
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, 32'(out_valid), 32'(t.v));
    chk({nm, ".data"}, 32'(out_data), 32'(t.dat));
    chk({nm, ".starve"}, 32'(starve_evt), 32'(t.se));
  endtask

  vec_t t;

  initial begin
    rst = 1'b1; req = '0; sel = '0; in_data = '0; out_ready = 1'b1;

    //         rst  req    sel  d0      d1      d2      d3      rdy  pop    v  dat     se
    tbl[0]  = '{1, 4'hF, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 4'h0, 0, 16'h0, 0};
    tbl[1]  = '{1, 4'hF, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 4'h0, 0, 16'h0, 0};
    tbl[2]  = '{0, 4'h4, 2, 16'h0, 16'h0, 16'hA5A5, 16'h0, 1, 4'h4, 1, 16'hA5A5, 0};
    tbl[3]  = '{0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 4'h0, 0, 16'hA5A5, 0};
    tbl[4]  = '{0, 4'h2, 3, 16'h0, 16'h1111, 16'h0, 16'h0, 1, 4'h2, 1, 16'h1111, 0};
    tbl[5]  = '{0, 4'h3, 0, 16'h2222, 16'h9999, 16'h0, 16'h0, 1, 4'h1, 1, 16'h2222, 0};
    for (int i = 6; i < 11; i++)
      tbl[i] = '{0, 4'h3, 0, 16'h3333, 16'h9999, 16'h0, 16'h0, 0, 4'h0, 1, 16'h2222, 0};
    tbl[11] = '{0, 4'h3, 0, 16'h3333, 16'h9999, 16'h0, 16'h0, 1, 4'h1, 1, 16'h3333, 0};

    for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));

    // cnt[1] held at 1 through the stall, so six more losses reach the limit
    for (int k = 0; k < 6; k++) begin
      t = '{0, 4'h3, 0, 16'h5000 + 16'(k), 16'h7777, 16'h0, 16'h0, 1, 4'h1, 1,
            16'h5000 + 16'(k), 0};
      step(t, $sformatf("bp_cnt%0d", k));
    end
    t = '{0, 4'h3, 0, 16'h5555, 16'h7777, 16'h0, 16'h0, 1, 4'h2, 1, 16'h7777, 1};
    step(t, "bp_ovr");
    t = '{0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 4'h0, 0, 16'h7777, 0};
    step(t, "bp_drain");

    // Starvation of input 3 behind fixed priority on input 0
    for (int k = 0; k < 8; k++) begin
      t = '{0, 4'h9, 0, 16'h4000 + 16'(k), 16'h0, 16'h0, 16'hBEEF, 1, 4'h1, 1,
            16'h4000 + 16'(k), 0};
      step(t, $sformatf("stv%0d", k));
    end
    t = '{0, 4'h9, 0, 16'h4008, 16'h0, 16'h0, 16'hBEEF, 1, 4'h8, 1, 16'hBEEF, 1};
    step(t, "stv_ovr");
    t = '{0, 4'h9, 0, 16'h4009, 16'h0, 16'h0, 16'hBEEF, 1, 4'h1, 1, 16'h4009, 0};
    step(t, "stv_after");
    t = '{0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 4'h0, 0, 16'h4009, 0};
    step(t, "stv_drain");

    // Back-to-back streaming from input 1
    for (int k = 0; k < 10; k++) begin
      t = '{0, 4'h2, 1, 16'h0, 16'h1000 + 16'(k), 16'h0, 16'h0, 1, 4'h2, 1,
            16'h1000 + 16'(k), 0};
      step(t, $sformatf("strm%0d", k));
    end

    // Reset while a flit is held
    t = '{1, 4'h2, 1, 16'h0, 16'hDEAD, 16'h0, 16'h0, 1, 4'h0, 0, 16'h0, 0};
    step(t, "rst_mid");
    t = '{0, 4'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1, 4'h0, 0, 16'h0, 0};
    step(t, "rst_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
